machine_seq_ctrl: RTL
=====================

// Module: machine_seq_ctrl
// PURPOSE
//  Sequencer for the 3-bit D-flip-flop Moore FSM datapath (input x, outputs F, S[2:0]).
//  Takes a serial test pattern and resets the FSM. Drives the pattern onto x one bit per cycle.
//  Observes F/S after every bit, then reports the F-hit count, the first hit index and the final state.
//  Sits between the lab control logic (start/done handshake) and the FSM instance.
// PARAMETERS
//  LEN_MAX  16  maximum pattern length in bits
//  LEN_W    5   width of len and first_hit; must satisfy 2**LEN_W > LEN_MAX
//  CNT_W    5   width of the saturating F-hit counter
// PORTS
//  CLK        in   1        single clock, rising edge
//  RESET      in   1        synchronous, active-high reset
//  start      in   1        request a run; sampled only in IDLE
//  pattern    in   LEN_MAX  bit stream; bit 0 is driven first
//  len        in   LEN_W    number of bits to drive; values > LEN_MAX are clamped to LEN_MAX
//  x_out      out  1        to FSM x input
//  mach_reset out  1        to FSM RESET input
//  F_in       in   1        from FSM F output
//  S_in       in   3        from FSM S output
//  busy       out  1        high in CLEAR, RUN and SAMPLE
//  done       out  1        one-cycle pulse; results are valid from this cycle on
//  f_count    out  CNT_W    count of observations with F_in=1; saturates at 2**CNT_W-1
//  first_hit  out  LEN_W    1-based index of the first observation with F_in=1; 0 if none
//  last_S     out  3        S_in captured at the final observation
// BEHAVIOUR
//  Reset: state=IDLE. x_out, busy, done, f_count, first_hit, last_S = 0. mach_reset=1 while RESET=1.
//  mach_reset = RESET | (state==CLEAR); combinational. All other outputs are registered.
//  States:
//  - IDLE: start=1 with len!=0 -> latch pattern and clamped len, clear the results, go to CLEAR.
//    start=1 with len==0 -> clear the results, go to DONE. No mach_reset is issued in this case.
//  - CLEAR: one cycle with mach_reset=1 and x_out=0; go to RUN with idx=0.
//  - RUN: x_out = shreg[0]; shift right each cycle; idx++; stay for len cycles, then go to SAMPLE.
//  - Observation k (1..len) is F_in/S_in as seen in RUN cycle idx=k and, for k=len, in SAMPLE.
//    F_in in RUN cycle idx=0 reflects the reset state and is ignored.
//  - SAMPLE: x_out=0; take the last observation; last_S <= S_in; go to DONE.
//    The FSM transition caused by this cycle is don't-care.
//  - DONE: done=1 for one cycle; go to IDLE. Results hold until the next accepted start.
//  Latency: start sampled at edge t -> CLEAR in cycle t+1, done high in cycle t+len+3.
//  start while busy or in DONE is ignored; it is not queued.
//  pattern and len are ignored after latching; changing them mid-run has no effect.
//  f_count saturates and does not wrap. first_hit is written only while it is still 0.
//  RESET mid-run -> IDLE next cycle, all results zeroed, no done pulse.
// CONFIGURATION
//  HALT_ON_F_EN defined: the first observation with F_in=1 ends the run.
//  - last_S <= S_in at that observation; f_count=1; first_hit=k.
//  - Next state is DONE directly (skips any remaining RUN and SAMPLE).
//  HALT_ON_F_EN undefined: the full len bits are always driven; behaviour is as above.
// STRUCTURE
//  Package machine_seq_pkg holds:
//  - state encodings ST_IDLE=0, ST_CLEAR=1, ST_RUN=2, ST_SAMPLE=3, ST_DONE=4 (3 bits)
//  - the default LEN_MAX/LEN_W/CNT_W constants
//  Sub-module seq_shift_reg: LEN_MAX-bit load/shift-right register.
//  - Inputs: load, shift, d. Output: q0.
//  FSM, index counter and result registers live in machine_seq_ctrl.
// TESTING
//  Bench uses a stub driving F_in/S_in, plus one integration run with the real FSM.
//  1. RESET=1 for 2 cycles -> busy=0, done=0, f_count=0, first_hit=0, last_S=0, x_out=0, mach_reset=1.
//  2. len=4, pattern=4'b1011, start -> mach_reset high 1 cycle; x_out 1,1,0,1;
//     busy high for 6 cycles; done high in cycle t+7.
//  3. len=4, stub F_in=1 at observations 2 and 4, S_in=3'b111 at the last observation
//     -> f_count=2, first_hit=2, last_S=3'b111.
//  4. len=0, start -> done in cycle t+1, busy never high, no mach_reset, f_count=0.
//  5. start pulsed mid-RUN -> ignored, single done. RESET mid-RUN -> IDLE, results 0, no done.
//  6. CNT_W=2, len=8, F_in stuck at 1:
//     - without HALT_ON_F_EN -> f_count=3, first_hit=1
//     - with HALT_ON_F_EN -> f_count=1, first_hit=1, done in cycle t+4

Source files
------------

// File: rtl/machine_seq_pkg.sv
// Shared state encoding and default sizing for the Moore-FSM test sequencer.
package machine_seq_pkg;

  localparam int LEN_MAX_DEF = 16;
  localparam int LEN_W_DEF   = 5;
  localparam int CNT_W_DEF   = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_RUN    = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/seq_shift_reg.sv
// Load/shift-right register that serialises the test pattern, bit 0 first.
module seq_shift_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic         q0
);

  logic [W-1:0] shreg_r;

  // load wins over shift so a fresh pattern is never disturbed on its first edge
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_r <= '0;
    end else if (load) begin
      shreg_r <= d;
    end else if (shift) begin
      shreg_r <= {1'b0, shreg_r[W-1:1]};
    end else begin
      shreg_r <= shreg_r;
    end
  end

  assign q0 = shreg_r[0];

endmodule

// File: rtl/machine_seq_ctrl.sv
// Sequencer that resets the 3-bit Moore FSM, streams a pattern onto x and scores F/S.
// Optional HALT_ON_F_EN: the first F=1 observation ends the run early.
module machine_seq_ctrl
  import machine_seq_pkg::*;
#(
  parameter int LEN_MAX = LEN_MAX_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               start,
  input  logic [LEN_MAX-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               x_out,
  output logic               mach_reset,
  input  logic               F_in,
  input  logic [2:0]         S_in,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   f_count,
  output logic [LEN_W-1:0]   first_hit,
  output logic [2:0]         last_S
);

  state_t             state_r;
  logic [LEN_W-1:0]   len_r;
  logic [LEN_W-1:0]   idx_r;
  logic               x_r;
  logic               busy_r;
  logic               done_r;
  logic [CNT_W-1:0]   f_count_r;
  logic [LEN_W-1:0]   first_hit_r;
  logic [2:0]         last_s_r;

  logic [LEN_W-1:0]   len_clamp_s;
  logic               load_s;
  logic               shift_s;
  logic               q0_s;
  logic               obs_valid_s;
  logic [LEN_W-1:0]   obs_idx_s;
  logic               hit_s;
  logic               halt_s;
  logic [CNT_W-1:0]   f_count_next_s;
  logic [LEN_W-1:0]   first_hit_next_s;

  assign len_clamp_s = (len > LEN_W'(LEN_MAX)) ? LEN_W'(LEN_MAX) : len;
  assign load_s      = (state_r == ST_IDLE) && start && (len != '0);
  assign shift_s     = (state_r == ST_CLEAR) || (state_r == ST_RUN);

  seq_shift_reg #(.W(LEN_MAX)) u_shreg (
    .clk   (CLK),
    .rst   (RESET),
    .load  (load_s),
    .shift (shift_s),
    .d     (pattern),
    .q0    (q0_s)
  );

  // RUN idx=0 still shows the FSM's reset state, so only idx>=1 and SAMPLE are observations
  assign obs_valid_s      = (state_r == ST_SAMPLE) || ((state_r == ST_RUN) && (idx_r != '0));
  assign obs_idx_s        = (state_r == ST_SAMPLE) ? len_r : idx_r;
  assign hit_s            = obs_valid_s & F_in;
  assign f_count_next_s   = (hit_s && (f_count_r != '1)) ? f_count_r + CNT_W'(1) : f_count_r;
  assign first_hit_next_s = (hit_s && (first_hit_r == '0)) ? obs_idx_s : first_hit_r;

`ifdef HALT_ON_F_EN
  assign halt_s = hit_s;
`else
  assign halt_s = 1'b0;
`endif

  assign mach_reset = RESET | (state_r == ST_CLEAR);

  // sequencer FSM with index counter and registered results
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r     <= ST_IDLE;
      len_r       <= '0;
      idx_r       <= '0;
      x_r         <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      f_count_r   <= '0;
      first_hit_r <= '0;
      last_s_r    <= 3'b000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          x_r    <= 1'b0;
          if (start) begin
            f_count_r   <= '0;
            first_hit_r <= '0;
            last_s_r    <= 3'b000;
            idx_r       <= '0;
            if (len == '0) begin
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              len_r   <= len_clamp_s;
              busy_r  <= 1'b1;
              state_r <= ST_CLEAR;
            end
          end
        end
        ST_CLEAR: begin
          x_r     <= q0_s;
          idx_r   <= '0;
          state_r <= ST_RUN;
        end
        ST_RUN: begin
          f_count_r   <= f_count_next_s;
          first_hit_r <= first_hit_next_s;
          if (halt_s) begin
            last_s_r <= S_in;
            x_r      <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            state_r  <= ST_DONE;
          end else if (idx_r == (len_r - LEN_W'(1))) begin
            x_r     <= 1'b0;
            state_r <= ST_SAMPLE;
          end else begin
            x_r   <= q0_s;
            idx_r <= idx_r + LEN_W'(1);
          end
        end
        ST_SAMPLE: begin
          f_count_r   <= f_count_next_s;
          first_hit_r <= first_hit_next_s;
          last_s_r    <= S_in;
          x_r         <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b1;
          state_r     <= ST_DONE;
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          x_r     <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign x_out     = x_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign f_count   = f_count_r;
  assign first_hit = first_hit_r;
  assign last_S    = last_s_r;

endmodule
